// File: rtl/demux_pkg.sv
// demux_pkg: shared state encoding, lane indices and default lane width for the demux frame controller
package demux_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/demux_lane_shreg.sv
// demux_lane_shreg: MSB-first shift register with shift enable and synchronous clear
module demux_lane_shreg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) q <= clr ? '0 : en ? {q[WIDTH-2:0], d} : q;
endmodule

// File: rtl/demux_frame_ctrl.sv
// demux_frame_ctrl: round-robin demux sequencer that captures a TDM stream into four lane words
module demux_frame_ctrl
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             s0,
    output logic             s1,
    input  logic             y0,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] lane0,
    output logic [WIDTH-1:0] lane1,
    output logic [WIDTH-1:0] lane2,
    output logic [WIDTH-1:0] lane3,
    output logic             lane_err
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t state, state_nx;
    logic [1:0] sel;
    logic [CW-1:0] round;
    logic [3:0] ys;
    logic [WIDTH-1:0] lane_q [4];
    logic enter, acc, last;
    assign ys = {y3, y2, y1, y0};
    assign enter = state == IDLE && start && !abort;
    assign acc = state == RUN && in_valid && !abort;
    assign last = acc && sel == LANE3 && round == CW'(WIDTH - 1);
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
    // abort wins over completion and handshake; it is a no-op in IDLE
    always_comb
        state_nx = abort && state != IDLE ? IDLE
                 : enter ? RUN
                 : last ? HOLD
                 : state == HOLD && out_ready ? IDLE
                 : state;
    always_comb begin
        busy = state == RUN;
        out_valid = state == HOLD;
        {s1, s0} = busy ? sel : 2'b00;
    end
    always_ff @(posedge clk) begin
        if (!rst_n || enter) begin
            sel <= '0;
            round <= '0;
            lane_err <= 1'b0;
        end else if (acc) begin
            sel <= sel + 2'd1;
            round <= sel == LANE3 ? round + CW'(1) : round;
            lane_err <= lane_err | (|(ys & ~(4'b0001 << sel)));
        end
    end
    for (genvar i = 0; i < 4; i++) begin : g_lane
        demux_lane_shreg #(.WIDTH(WIDTH)) u_shreg (
            .clk(clk),
            .clr(!rst_n || enter),
            .en (acc && sel == 2'(i)),
            .d  (ys[i]),
            .q  (lane_q[i])
        );
    end
    assign lane0 = lane_q[LANE0];
    assign lane1 = lane_q[LANE1];
    assign lane2 = lane_q[LANE2];
    assign lane3 = lane_q[LANE3];
endmodule

// File: doc/demux_frame_ctrl.md
Name: demux_frame_ctrl

Overview:
Sequencing and capture stage wrapped around the 4-way bit demultiplexer. Drives the demux select lines s1/s0 round-robin over a serial TDM bitstream, and collects the demux outputs y0..y3 back into four parallel lane words. When a full frame of WIDTH bits per lane has been captured, it presents the frame downstream with a valid/ready handshake.

Parameters:
WIDTH, 8, bits captured per lane per frame (>=2)
CW, $clog2(WIDTH)+1, round-counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset; one clock; reset is synchronous and active-low
start  input  1  begin frame capture (honoured only in IDLE)
abort  input  1  synchronous abort of the current frame
in_valid  input  1  the serial bit on the demux input is valid this cycle
s0  output  1  demux select LSB
s1  output  1  demux select MSB
y0,y1,y2,y3  input  1 each  demux outputs, combinational from the current s1/s0
busy  output  1  high in RUN
out_valid  output  1  frame available
out_ready  input  1  downstream accepts frame
lane0,lane1,lane2,lane3  output  WIDTH each  captured lane words
lane_err  output  1  sticky: a non-selected y was 1 on an accepted cycle

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; s1,s0=0; lane0..3=0; out_valid=0; busy=0; lane_err=0; counters=0. Reset has priority over all inputs and applies mid-frame or during HOLD.
- States: IDLE, RUN, HOLD.
- IDLE: s1,s0=00. start=1 -> RUN next cycle; lane registers, sel counter and round counter are cleared on entry; lane_err is cleared.
- RUN: busy=1. {s1,s0}=sel. On every cycle with in_valid=1 (accepted sample):
  - lane[sel] <= {lane[sel][WIDTH-2:0], y[sel]}, i.e. MSB-first shift-left.
  - sel increments mod 4 (00->01->10->11->00).
  - On the 11->00 wrap, round increments.
- in_valid=0 in RUN: no shift, and sel/round hold (stall of any length).
- Frame complete: the accepted sample with sel=11 and round=WIDTH-1 moves the state to HOLD. out_valid=1 from the next cycle, so latency is 1 clk after the last accepted sample. The frame is 4*WIDTH accepted samples.
- HOLD: out_valid=1; lane0..3 are stable; s1,s0=00; in_valid is ignored. A cycle with out_valid=1 and out_ready=1 completes the transfer -> IDLE, out_valid=0 next cycle. out_ready may be high before out_valid; this is not a transfer by itself. start in HOLD is ignored.
- start in RUN is ignored. There is no restart without going through IDLE.
- abort=1 in RUN or HOLD -> IDLE next cycle; out_valid=0; lane contents are left as-is (not guaranteed meaningful). abort has priority over out_ready and frame completion in the same cycle. abort in IDLE has no effect, and start is ignored in a cycle with abort=1.
- lane_err: on any accepted RUN cycle where any y_k with k!=sel is 1, lane_err <= 1. It stays set until the next IDLE->RUN transition or reset. It does not alter capture.
- Select outputs are registered from sel. The demux outputs are sampled in the same cycle as the select they were produced from.

Decomposition:
- Shared package demux_pkg holds:
  - state enum {IDLE, RUN, HOLD}
  - lane index constants LANE0..LANE3 = 2'd0..2'd3
  - the default WIDTH constant
- One natural sub-module: demux_lane_shreg, a WIDTH-bit MSB-first shift register with shift-enable and synchronous clear, instantiated four times. Enable = accepted sample AND sel==index.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> all outputs 0, s1s0=00. start=0 for 10 cycles -> state stays IDLE, busy=0.
- Basic frame, WIDTH=8, ideal demux model, in_valid held 1: serial stream of lane0=0xA5, lane1=0x3C, lane2=0xFF, lane3=0x01, interleaved MSB-first. After 32 accepted cycles, out_valid=1 on the next cycle with those values. s1s0 sequence is 00,01,10,11 repeating. lane_err=0.
- Stalls: same frame with in_valid toggling pseudo-randomly (about 50%) -> identical lane values. sel never advances on in_valid=0 cycles.
- Backpressure: out_ready held 0 for 20 cycles in HOLD -> lanes stable, out_valid stays 1. out_ready=1 -> one transfer, IDLE next cycle.
- Abort and reset mid-frame: abort after 13 accepted samples -> IDLE, out_valid never asserts; a following start then a full frame captures correctly. Repeat with rst_n=0 mid-frame -> all outputs 0.
- Error injection: force y2=1 while sel=00 on one accepted cycle -> lane_err=1 and held through HOLD. Cleared on the next start.
